wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter FAIR, default 1; 1 selects round-robin tie-break and 0 selects fixed priority to requester B.
REQ-002 The block SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  in  1  the reset, asynchronous and active-low.
REQ-004 The block SHALL have ports a_valid in 1, a_rd in 5 and a_data in 32: requester A (ALU/CSR writeback) request, destination and data.
REQ-005 The block SHALL have port a_ready  out  1  requester A accepted this cycle.
REQ-006 The block SHALL have ports b_valid in 1, b_rd in 5 and b_data in 32: requester B (load unit) request, destination and data.
REQ-007 The block SHALL have port b_ready  out  1  requester B accepted this cycle.
REQ-008 The block SHALL have ports iss_valid in 1 and iss_rd in 5: an issued instruction will write iss_rd.
REQ-009 The block SHALL have ports rs1 in 5 and rs2 in 5: source registers to hazard-check.
REQ-010 The block SHALL have ports rs1_busy out 1 and rs2_busy out 1: the source register has a pending write.
REQ-011 The block SHALL have ports rf_wr out 1, rf_rd out 5 and rf_data out 32: registered register-file write port (wr, rd, rd_data).
REQ-012 The block SHALL have port sb_err  out  1  one-cycle scoreboard-violation pulse.

Function
REQ-013 Transfer SHALL occur on a requester when valid and ready are both 1 at a rising clk edge.
REQ-014 Requesters SHALL hold valid, rd and data stable until ready; the block SHALL NOT depend on ready-before-valid.
REQ-015 a_ready and b_ready SHALL be combinational, at most one SHALL be 1 in any cycle, and neither SHALL be 1 while its valid is 0.
REQ-016 When exactly one valid is 1, that requester SHALL be granted.
REQ-017 When both valids are 1 and FAIR=1, the requester not granted in the most recent tie SHALL be granted; when FAIR=0, B SHALL be granted.
REQ-018 A last_tie register SHALL update only on tie cycles.
REQ-019 Latency SHALL be one cycle: a transfer at edge N drives rf_wr/rf_rd/rf_data during cycle N+1.
REQ-020 With no transfer, rf_wr SHALL be 0 the next cycle, and rf_rd/rf_data SHALL hold.
REQ-021 A transfer with rd=0 SHALL complete the handshake with rf_wr=0 the next cycle, so x0 is never written.
REQ-022 Throughput SHALL be one write per cycle, with no bubbles between back-to-back transfers.
REQ-023 A 32-bit pending vector SHALL be kept; bit 0 SHALL be constant 0.
REQ-024 iss_valid with iss_rd!=0 SHALL set pending[iss_rd] at the edge.
REQ-025 In a cycle with rf_wr=1, pending[rf_rd] SHALL clear at the end edge, which is the same edge the register file commits.
REQ-026 Simultaneous set and clear of the same register SHALL leave the bit set, since the new producer wins.
REQ-027 rsN_busy SHALL equal pending[rsN] combinationally, with rs=0 always 0 and no bypass.
REQ-028 sb_err SHALL pulse 1 for one cycle after an edge where iss_rd!=0 hits an already-pending bit that is not being cleared that edge.
REQ-029 sb_err SHALL pulse 1 for one cycle after an edge where rf_wr=1 with rf_rd!=0 and pending[rf_rd]=0.
REQ-030 Scoreboard state SHALL NOT alter arbitration; sb_err SHALL be diagnostic only.

Reset
REQ-031 rst_n=0 SHALL asynchronously clear rf_wr, rf_rd, rf_data, sb_err, the pending vector and last_tie (last_tie=A, so B wins the first FAIR tie).
REQ-032 a_ready and b_ready SHALL be 0 while rst_n=0.
REQ-033 Reset mid-operation SHALL discard any registered write and all pending bits.
REQ-034 After rst_n deasserts, the first transfer SHALL be accepted at the first rising edge.

Verification
REQ-035 Scenario: iss x5; A valid rd=5 data=0xDEADBEEF -> a_ready=1, next cycle rf_wr=1 rf_rd=5 rf_data=0xDEADBEEF, rs1=5 busy 1 until that cycle, 0 after.
REQ-036 Scenario: FAIR=1, A and B both valid for 4 cycles (rd 1..4) -> grants B,A,B,A; rf_wr=1 on 4 consecutive cycles.
REQ-037 Scenario: FAIR=0, A and B both valid -> B granted every cycle while b_valid=1; A granted the cycle after b_valid drops.
REQ-038 Scenario: B valid rd=0 data=0x1234 -> b_ready=1, next cycle rf_wr=0, sb_err=0.
REQ-039 Scenario: iss x7 twice with no intervening write -> sb_err=1 one cycle; iss x7 in the same cycle rf_wr=1 rf_rd=7 -> pending[7] stays 1, sb_err=0.
REQ-040 Scenario: rst_n=0 mid-cycle with rf_wr=1 and pending x3 -> rf_wr=0 and rs1=3 busy 0 immediately, without a clock edge.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: two requesters, issue/hazard query and register-file write port.
// Pure signal bundle; no latency of its own.
// Requesters hold valid/rd/data until ready; the arbiter side drives ready combinationally.
interface wb_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        b_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_wr;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic        sb_err;

    // Pipeline side: requesters, issue stage and hazard query.
    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output iss_valid, iss_rd, rs1, rs2,
        input  a_ready, b_ready, rs1_busy, rs2_busy,
        input  rf_wr, rf_rd, rf_data, sb_err
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  iss_valid, iss_rd, rs1, rs2,
        output a_ready, b_ready, rs1_busy, rs2_busy,
        output rf_wr, rf_rd, rf_data, sb_err
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks A or B onto one register-file write port and tracks pending writes.
// Latency: one cycle from accepted transfer to rf_wr/rf_rd/rf_data; one write per cycle.
// Backpressure: at most one ready per cycle, ready only with valid; the loser simply holds.
module wb_arbiter #(
    parameter int FAIR = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_arbiter_if.slave bus
);

    localparam logic TIE_A = 1'b0;
    localparam logic TIE_B = 1'b1;

    logic        r_last_tie;
    logic        r_rf_wr;
    logic [4:0]  r_rf_rd;
    logic [31:0] r_rf_data;
    logic        r_sb_err;
    logic [31:0] r_pending;

    logic        w_tie;
    logic        w_grant_a;
    logic        w_grant_b;
    logic        w_xfer;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic [31:0] w_set;
    logic [31:0] w_clr;
    logic [31:0] w_pend_nxt;
    logic        w_err_nxt;

    // Grant selection: single requester wins outright; ties go round-robin or to B.
    always_comb begin
        w_tie     = bus.a_valid & bus.b_valid;
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (rst_n) begin
            if (w_tie) begin
                if (FAIR != 0 && r_last_tie == TIE_B) begin
                    w_grant_a = 1'b1;
                end else begin
                    w_grant_b = 1'b1;
                end
            end else begin
                w_grant_a = bus.a_valid;
                w_grant_b = bus.b_valid;
            end
        end
        w_xfer = w_grant_a | w_grant_b;
        w_rd   = w_grant_a ? bus.a_rd   : bus.b_rd;
        w_data = w_grant_a ? bus.a_data : bus.b_data;
    end

    // Scoreboard next state: new producer beats the retiring write on the same register.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (bus.iss_valid && bus.iss_rd != 5'd0) begin
            w_set[bus.iss_rd] = 1'b1;
        end
        if (r_rf_wr && r_rf_rd != 5'd0) begin
            w_clr[r_rf_rd] = 1'b1;
        end
        w_pend_nxt = ((r_pending & ~w_clr) | w_set) & ~32'h1;
        w_err_nxt  = (|(w_set & r_pending & ~w_clr))
                   | (r_rf_wr && r_rf_rd != 5'd0 && !r_pending[r_rf_rd]);
    end

    // Remember who won the latest tie; untouched on non-tie cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_tie <= TIE_A;
        end else if (w_tie) begin
            r_last_tie <= w_grant_b ? TIE_B : TIE_A;
        end
    end

    // Register-file write port; rd=0 transfers handshake but never write x0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_wr   <= 1'b0;
            r_rf_rd   <= 5'd0;
            r_rf_data <= 32'd0;
        end else begin
            r_rf_wr <= w_xfer && (w_rd != 5'd0);
            if (w_xfer) begin
                r_rf_rd   <= w_rd;
                r_rf_data <= w_data;
            end
        end
    end

    // Pending vector and diagnostic error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 32'd0;
            r_sb_err  <= 1'b0;
        end else begin
            r_pending <= w_pend_nxt;
            r_sb_err  <= w_err_nxt;
        end
    end

    assign bus.a_ready  = w_grant_a;
    assign bus.b_ready  = w_grant_b;
    assign bus.rs1_busy = r_pending[bus.rs1];
    assign bus.rs2_busy = r_pending[bus.rs2];
    assign bus.rf_wr    = r_rf_wr;
    assign bus.rf_rd    = r_rf_rd;
    assign bus.rf_data  = r_rf_data;
    assign bus.sb_err   = r_sb_err;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: instance 0 is FAIR=1, instance 1 is FAIR=0.
// Directed scenarios with literal expectations, then randomized traffic against a model.
// Model is updated on each rising edge; one process compares every output on the falling edge.
module tb_wb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       a_valid, b_valid;
    logic [1:0][4:0]  a_rd, b_rd;
    logic [1:0][31:0] a_data, b_data;
    logic             iss_valid;
    logic [4:0]       iss_rd, rs1, rs2;
    logic [1:0]       a_ready, b_ready, rs1_busy, rs2_busy, rf_wr, sb_err;
    logic [1:0][4:0]  rf_rd;
    logic [1:0][31:0] rf_data;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wb_arbiter_if ifc ();
        assign ifc.a_valid   = a_valid[g];
        assign ifc.a_rd      = a_rd[g];
        assign ifc.a_data    = a_data[g];
        assign ifc.b_valid   = b_valid[g];
        assign ifc.b_rd      = b_rd[g];
        assign ifc.b_data    = b_data[g];
        assign ifc.iss_valid = iss_valid;
        assign ifc.iss_rd    = iss_rd;
        assign ifc.rs1       = rs1;
        assign ifc.rs2       = rs2;
        assign a_ready[g]    = ifc.a_ready;
        assign b_ready[g]    = ifc.b_ready;
        assign rs1_busy[g]   = ifc.rs1_busy;
        assign rs2_busy[g]   = ifc.rs2_busy;
        assign rf_wr[g]      = ifc.rf_wr;
        assign rf_rd[g]      = ifc.rf_rd;
        assign rf_data[g]    = ifc.rf_data;
        assign sb_err[g]     = ifc.sb_err;
        wb_arbiter #(.FAIR((g == 0) ? 1 : 0)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc)
        );
    end

    // Behavioural model state.
    logic [1:0][31:0] m_pend;
    logic [1:0]       m_bnext;   // 1: B wins the next fair tie
    logic [1:0]       e_wr, e_err, acc_a, acc_b;
    logic [1:0][4:0]  e_rd;
    logic [1:0][31:0] e_data;

    int n_chk  = 0;
    int n_fail = 0;
    bit rnd    = 1'b0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got %0h want %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Expected grant {b,a} from current inputs and tie history.
    function automatic logic [1:0] grant(input int k);
        if (!rst_n) return 2'b00;
        if (a_valid[k] && b_valid[k]) return (k == 1 || m_bnext[k]) ? 2'b10 : 2'b01;
        return {b_valid[k], a_valid[k]};
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_bnext = 2'b11;
        e_wr    = '0;
        e_err   = '0;
        e_rd    = '0;
        e_data  = '0;
        acc_a   = '0;
        acc_b   = '0;
    endtask

    task automatic model_update();
        logic [1:0]  g;
        logic        clr, err;
        logic [31:0] np;
        logic [4:0]  r;
        if (!rst_n) return;
        for (int k = 0; k < 2; k++) begin
            g = grant(k);
            acc_a[k] = g[0];
            acc_b[k] = g[1];
            clr = e_wr[k] && e_rd[k] != 5'd0;
            err = clr && !m_pend[k][e_rd[k]];
            np  = m_pend[k];
            if (clr) np[e_rd[k]] = 1'b0;
            if (iss_valid && iss_rd != 5'd0) begin
                if (m_pend[k][iss_rd] && !(clr && e_rd[k] == iss_rd)) err = 1'b1;
                np[iss_rd] = 1'b1;
            end
            m_pend[k] = np;
            e_err[k]  = err;
            if (a_valid[k] && b_valid[k]) m_bnext[k] = g[0];
            if (g != 2'b00) begin
                r         = g[0] ? a_rd[k] : b_rd[k];
                e_wr[k]   = (r != 5'd0);
                e_rd[k]   = r;
                e_data[k] = g[0] ? a_data[k] : b_data[k];
            end else begin
                e_wr[k] = 1'b0;
            end
        end
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < 2; k++) begin
            if (!a_valid[k] || acc_a[k]) begin
                a_valid[k] = ($urandom_range(3, 0) != 0);
                a_rd[k]    = 5'($urandom_range(7, 0));
                a_data[k]  = $urandom;
            end
            if (!b_valid[k] || acc_b[k]) begin
                b_valid[k] = ($urandom_range(3, 0) != 0);
                b_rd[k]    = 5'($urandom_range(7, 0));
                b_data[k]  = $urandom;
            end
        end
        iss_valid = ($urandom_range(2, 0) == 0);
        iss_rd    = 5'($urandom_range(7, 0));
        rs1       = 5'($urandom_range(7, 0));
        rs2       = 5'($urandom_range(7, 0));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        if (rnd) randomize_inputs();
    endtask

    task automatic clear_inputs();
        a_valid   = '0;
        b_valid   = '0;
        iss_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) cycle();
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin : cmp
        logic [1:0] g;
        for (int k = 0; k < 2; k++) begin
            g = grant(k);
            chk("a_ready", k, a_ready[k], g[0]);
            chk("b_ready", k, b_ready[k], g[1]);
            chk("rf_wr", k, rf_wr[k], e_wr[k]);
            chk("rf_rd", k, rf_rd[k], e_rd[k]);
            chk("rf_data", k, rf_data[k], e_data[k]);
            chk("sb_err", k, sb_err[k], e_err[k]);
            chk("rs1_busy", k, rs1_busy[k], (rs1 != 0) && m_pend[k][rs1]);
            chk("rs2_busy", k, rs2_busy[k], (rs2 != 0) && m_pend[k][rs2]);
        end
    end

    logic [1:0] exp_b;
    logic [4:0] ar, br;

    initial begin
        rst_n  = 1'b0;
        a_rd   = '0; b_rd = '0; a_data = '0; b_data = '0;
        iss_rd = '0; rs1 = 5'd5; rs2 = 5'd0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset: readies held low even with valids asserted.
        a_valid = 2'b11; b_valid = 2'b11;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_a_ready", k, a_ready[k], 1'b0);
            chk("rst_b_ready", k, b_ready[k], 1'b0);
            chk("rst_rf_wr", k, rf_wr[k], 1'b0);
            chk("rst_sb_err", k, sb_err[k], 1'b0);
            chk("rst_busy", k, rs1_busy[k], 1'b0);
        end
        clear_inputs();
        rst_n = 1'b1;

        // Issue x5, then A writes x5.
        iss_valid = 1'b1; iss_rd = 5'd5;
        cycle();
        iss_valid = 1'b0;
        a_valid[0] = 1'b1; a_rd[0] = 5'd5; a_data[0] = 32'hDEADBEEF;
        #1;
        chk("s35_a_ready", 0, a_ready[0], 1'b1);
        chk("s35_busy_pre", 0, rs1_busy[0], 1'b1);
        cycle();
        a_valid[0] = 1'b0;
        #1;
        chk("s35_rf_wr", 0, rf_wr[0], 1'b1);
        chk("s35_rf_rd", 0, rf_rd[0], 5'd5);
        chk("s35_rf_data", 0, rf_data[0], 32'hDEADBEEF);
        chk("s35_busy_wr", 0, rs1_busy[0], 1'b1);
        cycle();
        #1;
        chk("s35_rf_wr_after", 0, rf_wr[0], 1'b0);
        chk("s35_busy_after", 0, rs1_busy[0], 1'b0);
        idle(2);

        // Fair ties: B, A, B, A with back-to-back writes.
        ar = 5'd1; br = 5'd9;
        a_valid[0] = 1'b1; b_valid[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_rd[0] = ar; a_data[0] = {27'd0, ar};
            b_rd[0] = br; b_data[0] = {27'd0, br};
            exp_b = (i % 2 == 0) ? 2'b10 : 2'b01;
            #1;
            chk("s36_grant", i, {b_ready[0], a_ready[0]}, exp_b);
            cycle();
            chk("s36_rf_wr", i, rf_wr[0], 1'b1);
            chk("s36_rf_rd", i, rf_rd[0], (i % 2 == 0) ? br : ar);
            if (i % 2 == 0) br = br + 5'd1;
            else            ar = ar + 5'd1;
        end
        idle(2);

        // Fixed priority (instance 1): B every cycle, A once B drops.
        a_valid[1] = 1'b1; a_rd[1] = 5'd3; a_data[1] = 32'h33;
        b_valid[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_rd[1] = 5'(20 + i); b_data[1] = 32'(i);
            #1;
            chk("s37_b_ready", i, b_ready[1], 1'b1);
            chk("s37_a_ready", i, a_ready[1], 1'b0);
            cycle();
        end
        b_valid[1] = 1'b0;
        #1;
        chk("s37_a_after", 1, a_ready[1], 1'b1);
        cycle();
        a_valid[1] = 1'b0;
        chk("s37_rf_rd", 1, rf_rd[1], 5'd3);
        idle(2);

        // rd=0 transfer: handshake but no write.
        b_valid[0] = 1'b1; b_rd[0] = 5'd0; b_data[0] = 32'h1234;
        #1;
        chk("s38_b_ready", 0, b_ready[0], 1'b1);
        cycle();
        b_valid[0] = 1'b0;
        #1;
        chk("s38_rf_wr", 0, rf_wr[0], 1'b0);
        chk("s38_sb_err", 0, sb_err[0], 1'b0);
        idle(2);

        // Double issue of x7, then issue racing its retiring write.
        iss_valid = 1'b1; iss_rd = 5'd7;
        cycle();
        cycle();
        iss_valid = 1'b0;
        #1;
        chk("s39_err", 0, sb_err[0], 1'b1);
        cycle();
        #1;
        chk("s39_err_one", 0, sb_err[0], 1'b0);
        a_valid[0] = 1'b1; a_rd[0] = 5'd7; a_data[0] = 32'h77;
        cycle();
        a_valid[0] = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
        #1;
        chk("s39_rf_wr", 0, rf_wr[0], 1'b1);
        chk("s39_rf_rd", 0, rf_rd[0], 5'd7);
        cycle();
        iss_valid = 1'b0;
        #1;
        chk("s39_still_busy", 0, rs1_busy[0], 1'b1);
        chk("s39_no_err", 0, sb_err[0], 1'b0);
        idle(2);

        // Asynchronous reset mid-cycle with a write in flight and x3 pending.
        iss_valid = 1'b1; iss_rd = 5'd3;
        cycle();
        iss_valid = 1'b0;
        a_valid[0] = 1'b1; a_rd[0] = 5'd5; a_data[0] = 32'h55;
        cycle();
        a_valid[0] = 1'b0; rs1 = 5'd3;
        #1;
        chk("s40_wr_before", 0, rf_wr[0], 1'b1);
        chk("s40_busy_before", 0, rs1_busy[0], 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("s40_wr_reset", 0, rf_wr[0], 1'b0);
        chk("s40_busy_reset", 0, rs1_busy[0], 1'b0);
        cycle();
        rst_n = 1'b1;
        idle(1);

        // Randomized traffic.
        rnd = 1'b1;
        randomize_inputs();
        repeat (3000) cycle();
        rnd = 1'b0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
